instruction_fetch_unit: RTL and testbench

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

---
 rtl/instruction_fetch_unit.sv | 97 +++++++++
 tb/tb_instruction_fetch_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Single-issue instruction fetch stage: PC register, IF/ID pipeline register,
// decode handshake with stall, redirect/flush, halt and an accept counter.
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_instr,
   output logic        if_valid,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   output logic [31:0] if_pc_plus4,
   input  logic        id_ready,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   input  logic        halt_req,
   output logic        misalign,
   output logic [31:0] fetch_count
);

   typedef enum logic [1:0] {FETCH, STALL, HALT} state_t;

   state_t      state, state_nxt;
   logic [31:0] pc;
   logic        xfer;     // decode takes the IF/ID contents this edge
   logic        do_load;  // capture imem_instr into IF/ID and advance PC
   logic        do_drop;  // halted: invalidate IF/ID once it has been taken

   assign xfer      = if_valid & id_ready;
   assign imem_addr = pc;

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= FETCH;
      else        state <= state_nxt;
   end

   // next state: redirect wins, then halt, then the stall handshake
   always_comb begin
      state_nxt = state;
      if (redirect_valid)  state_nxt = halt_req ? HALT : FETCH;
      else if (halt_req)   state_nxt = HALT;
      else begin
         case (state)
            FETCH, STALL: state_nxt = (if_valid && !id_ready) ? STALL : FETCH;
            HALT:         state_nxt = HALT;
            default:      state_nxt = FETCH;
         endcase
      end
   end

   // datapath controls; a stall releases and reloads on the same edge, so no bubble
   always_comb begin
      do_load = 1'b0;
      do_drop = 1'b0;
      if (!redirect_valid) begin
         if (halt_req || state == HALT) do_drop = xfer;
         else                           do_load = !if_valid || id_ready;
      end
   end

   // PC and IF/ID register; a redirect flushes even an instruction accepted this edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc          <= RESET_PC;
         if_valid    <= 1'b0;
         if_instr    <= '0;
         if_pc       <= '0;
         if_pc_plus4 <= '0;
      end else if (redirect_valid) begin
         pc       <= {redirect_target[31:2], 2'b00};
         if_valid <= 1'b0;
      end else if (do_load) begin
         if_instr    <= imem_instr;
         if_pc       <= pc;
         if_pc_plus4 <= pc + 32'd4;
         if_valid    <= 1'b1;
         pc          <= pc + 32'd4;
      end else if (do_drop) begin
         if_valid <= 1'b0;
      end
   end

   // sticky misaligned-target flag, cleared only by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                     misalign <= 1'b0;
      else if (redirect_valid && |redirect_target[1:0]) misalign <= 1'b1;
   end

   // accepted-instruction counter, counts even when a redirect flushes the slot
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    fetch_count <= '0;
      else if (xfer) fetch_count <= fetch_count + 32'd1;
   end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit; memory word i reads as 32'h1000_0000 + i.
module tb_instruction_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] imem_addr, imem_instr;
   logic        if_valid;
   logic [31:0] if_instr, if_pc, if_pc_plus4;
   logic        id_ready, redirect_valid, halt_req, misalign;
   logic [31:0] redirect_target, fetch_count;

   int n_chk = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   // combinational instruction memory model
   assign imem_instr = 32'h1000_0000 | {22'b0, imem_addr[11:2]};

   instruction_fetch_unit #(.RESET_PC(32'h0)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_addr(imem_addr), .imem_instr(imem_instr),
      .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_pc_plus4(if_pc_plus4),
      .id_ready(id_ready), .redirect_valid(redirect_valid), .redirect_target(redirect_target),
      .halt_req(halt_req), .misalign(misalign), .fetch_count(fetch_count)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // advance one rising edge and settle
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b1; id_ready = 1'b0; redirect_valid = 1'b0;
      redirect_target = '0; halt_req = 1'b0;
      #1 rst_n = 1'b0;
      #2;
      chk("rst_valid", {31'b0, if_valid}, 32'd0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_instr", if_instr, 32'h0);
      chk("rst_pc", if_pc, 32'h0);
      chk("rst_cnt", fetch_count, 32'd0);
      chk("rst_mis", {31'b0, misalign}, 32'd0);
      step();
      chk("rst_hold_valid", {31'b0, if_valid}, 32'd0);

      @(negedge clk);
      rst_n = 1'b1; id_ready = 1'b1;
      // sequential fetch of words 0..3
      step();
      chk("f0_pc", if_pc, 32'h0);
      chk("f0_instr", if_instr, 32'h1000_0000);
      chk("f0_valid", {31'b0, if_valid}, 32'd1);
      chk("f0_addr", imem_addr, 32'h4);
      step();
      chk("f1_pc", if_pc, 32'h4);
      chk("f1_instr", if_instr, 32'h1000_0001);
      chk("f1_cnt", fetch_count, 32'd1);
      step();
      chk("f2_pc", if_pc, 32'h8);
      chk("f2_p4", if_pc_plus4, 32'hC);
      chk("f2_cnt", fetch_count, 32'd2);

      // three stalled cycles holding the word at 8
      id_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("st_pc", if_pc, 32'h8);
         chk("st_instr", if_instr, 32'h1000_0002);
         chk("st_addr", imem_addr, 32'hC);
         chk("st_cnt", fetch_count, 32'd2);
      end
      id_ready = 1'b1;
      step();
      chk("rel_pc", if_pc, 32'hC);
      chk("rel_instr", if_instr, 32'h1000_0003);
      chk("rel_cnt", fetch_count, 32'd3);
      step();
      chk("f4_cnt", fetch_count, 32'd4);
      chk("f4_pc", if_pc, 32'h10);

      // redirect during stall
      id_ready = 1'b0;
      step();
      chk("st2_pc", if_pc, 32'h10);
      redirect_valid = 1'b1; redirect_target = 32'h40;
      step();
      chk("rd_valid", {31'b0, if_valid}, 32'd0);
      chk("rd_addr", imem_addr, 32'h40);
      chk("rd_cnt", fetch_count, 32'd4);
      redirect_valid = 1'b0; id_ready = 1'b1;
      step();
      chk("rd_pc", if_pc, 32'h40);
      chk("rd_instr", if_instr, 32'h1000_0010);
      chk("rd_p4", if_pc_plus4, 32'h44);
      step();
      chk("rd_cnt2", fetch_count, 32'd5);
      chk("rd_pc2", if_pc, 32'h44);

      // misaligned redirect, same edge as an acceptance
      redirect_valid = 1'b1; redirect_target = 32'h42;
      step();
      chk("mis_addr", imem_addr, 32'h40);
      chk("mis_flag", {31'b0, misalign}, 32'd1);
      chk("mis_valid", {31'b0, if_valid}, 32'd0);
      chk("mis_cnt", fetch_count, 32'd6);
      redirect_valid = 1'b0;
      step();
      chk("mis_pc", if_pc, 32'h40);
      chk("mis_cnt2", fetch_count, 32'd6);

      // halt with a held instruction
      id_ready = 1'b0; halt_req = 1'b1;
      step();
      chk("h_valid", {31'b0, if_valid}, 32'd1);
      chk("h_pc", if_pc, 32'h40);
      chk("h_addr", imem_addr, 32'h44);
      halt_req = 1'b0;
      step();
      chk("h_valid2", {31'b0, if_valid}, 32'd1);
      chk("h_addr2", imem_addr, 32'h44);
      id_ready = 1'b1;
      step();
      chk("h_acc_valid", {31'b0, if_valid}, 32'd0);
      chk("h_acc_cnt", fetch_count, 32'd7);
      step();
      chk("h_frz_valid", {31'b0, if_valid}, 32'd0);
      chk("h_frz_addr", imem_addr, 32'h44);
      chk("h_frz_cnt", fetch_count, 32'd7);
      redirect_valid = 1'b1; redirect_target = 32'h10;
      step();
      chk("hx_addr", imem_addr, 32'h10);
      chk("hx_mis", {31'b0, misalign}, 32'd1);
      redirect_valid = 1'b0;
      step();
      chk("hx_pc", if_pc, 32'h10);
      chk("hx_instr", if_instr, 32'h1000_0004);
      step();
      chk("hx_pc2", if_pc, 32'h14);
      chk("hx_cnt", fetch_count, 32'd8);

      // halt and redirect on the same edge
      halt_req = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h20;
      step();
      chk("hr_addr", imem_addr, 32'h20);
      chk("hr_valid", {31'b0, if_valid}, 32'd0);
      chk("hr_cnt", fetch_count, 32'd9);
      halt_req = 1'b0; redirect_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         chk("hr_idle_valid", {31'b0, if_valid}, 32'd0);
         chk("hr_idle_addr", imem_addr, 32'h20);
      end

      // PC wrap at the top of the address space
      redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
      step();
      chk("w_addr", imem_addr, 32'hFFFF_FFFC);
      redirect_valid = 1'b0;
      step();
      chk("w_pc", if_pc, 32'hFFFF_FFFC);
      chk("w_p4", if_pc_plus4, 32'h0);
      chk("w_instr", if_instr, 32'h1000_03FF);
      chk("w_addr2", imem_addr, 32'h0);
      step();
      chk("w_pc2", if_pc, 32'h0);
      chk("w_cnt", fetch_count, 32'd10);

      // reset asserted mid-stall discards the held word
      id_ready = 1'b0;
      step();
      chk("rs_stall_pc", if_pc, 32'h0);
      chk("rs_stall_mis", {31'b0, misalign}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rs_valid", {31'b0, if_valid}, 32'd0);
      chk("rs_cnt", fetch_count, 32'd0);
      chk("rs_mis", {31'b0, misalign}, 32'd0);
      chk("rs_addr", imem_addr, 32'h0);
      @(negedge clk);
      rst_n = 1'b1; id_ready = 1'b1;
      step();
      chk("rs_pc", if_pc, 32'h0);
      chk("rs_instr", if_instr, 32'h1000_0000);
      chk("rs_valid2", {31'b0, if_valid}, 32'd1);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
